// File: rtl/itr_priority_ctrl_if.sv
// Bundle between the stage-0 fetch controller and the interrupt priority controller.
// The controller connects through the slave modport and stage 0 through the master modport.
interface itr_priority_ctrl_if;
  logic [3:0] irq;
  logic [3:0] itr_mask;
  logic       itr_ack;
  logic       itr_ret;
  logic       i_pending;
  logic [7:0] vec_addr;
  logic       vec_valid;
  logic [3:0] itr_active;
  logic [3:0] pend_out;

  modport slave (
    input  irq, itr_mask, itr_ack, itr_ret,
    output i_pending, vec_addr, vec_valid, itr_active, pend_out
  );

  modport master (
    output irq, itr_mask, itr_ack, itr_ret,
    input  i_pending, vec_addr, vec_valid, itr_active, pend_out
  );
endinterface

// File: rtl/itr_priority_ctrl.sv
// Four-line fixed-priority interrupt controller with vectored acknowledge toward stage 0.
// Define ITR_NEST_EN to allow strictly higher-priority requests to preempt a running service.
module itr_priority_ctrl #(
  parameter logic [7:0]  VEC_BASE  = 8'hF0,
  parameter int unsigned VEC_SHIFT = 2
) (
  input logic                clk,
  input logic                clr,
  itr_priority_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    VEC     = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic [3:0] irq_d_r;
  logic [3:0] pend_r;
  logic [3:0] active_r;
  logic [3:0] active_nx_s;
  logic [7:0] vec_addr_r;
  logic       i_pending_r;
  logic       vec_valid_r;
  logic [3:0] rise_s;
  logic [3:0] cand_s;
  logic [3:0] clr_bit_s;
  logic [1:0] idx_s;
  logic       elig_s;
  logic       accept_s;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] r;
    if (v[0])      r = 2'd0;
    else if (v[1]) r = 2'd1;
    else if (v[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [7:0] vec_of(input logic [1:0] idx);
    logic [7:0] off;
    off = {6'd0, idx} << VEC_SHIFT;
    return VEC_BASE + off;
  endfunction

  assign rise_s    = bus.irq & ~irq_d_r;
  assign cand_s    = pend_r & bus.itr_mask;
  assign idx_s     = low_idx(cand_s);
  assign clr_bit_s = accept_s ? onehot(idx_s) : 4'b0000;

`ifdef ITR_NEST_EN
  // While a line is in service only a strictly higher-priority candidate may interrupt it.
  assign elig_s = (cand_s != 4'b0000) &&
                  ((active_r == 4'b0000) || (idx_s < low_idx(active_r)));
`else
  assign elig_s = (cand_s != 4'b0000);
`endif

  // Next-state and in-service bookkeeping for the request/vector/service sequence.
  always_comb begin
    state_nx_s  = state_r;
    active_nx_s = active_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (elig_s) state_nx_s = REQ;
        else        state_nx_s = IDLE;
      end
      REQ: begin
        if (!elig_s) begin
          state_nx_s = (active_r != 4'b0000) ? SERVICE : IDLE;
        end else if (bus.itr_ack) begin
          state_nx_s  = VEC;
          accept_s    = 1'b1;
          active_nx_s = active_r | onehot(idx_s);
        end else begin
          state_nx_s = REQ;
        end
      end
      VEC: begin
        state_nx_s = SERVICE;
      end
      SERVICE: begin
        if (bus.itr_ret) begin
          active_nx_s = active_r & ~onehot(low_idx(active_r));
          state_nx_s  = (active_nx_s != 4'b0000) ? SERVICE : IDLE;
        end
`ifdef ITR_NEST_EN
        else if (elig_s) begin
          state_nx_s = REQ;
        end
`endif
        else begin
          state_nx_s = SERVICE;
        end
      end
      default: begin
        state_nx_s  = IDLE;
        active_nx_s = 4'b0000;
      end
    endcase
  end

  // Edge capture, pending/active state and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r     <= IDLE;
      irq_d_r     <= 4'b0000;
      pend_r      <= 4'b0000;
      active_r    <= 4'b0000;
      vec_addr_r  <= 8'h00;
      i_pending_r <= 1'b0;
      vec_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      irq_d_r     <= bus.irq;
      pend_r      <= (pend_r & ~clr_bit_s) | rise_s;
      active_r    <= active_nx_s;
      i_pending_r <= (state_nx_s == REQ);
      vec_valid_r <= (state_nx_s == VEC);
      if (accept_s) vec_addr_r <= vec_of(idx_s);
      else          vec_addr_r <= vec_addr_r;
    end
  end

  assign bus.i_pending  = i_pending_r;
  assign bus.vec_addr   = vec_addr_r;
  assign bus.vec_valid  = vec_valid_r;
  assign bus.itr_active = active_r;
  assign bus.pend_out   = pend_r;

endmodule

// File: tb/tb_itr_priority_ctrl.sv
// Directed self-checking bench for itr_priority_ctrl; nesting expectations follow ITR_NEST_EN.
module tb_itr_priority_ctrl;
  logic clk;
  logic clr;
  int   checks;
  int   passed;

  itr_priority_ctrl_if bus ();
  itr_priority_ctrl_if bw ();

  itr_priority_ctrl dut (.clk(clk), .clr(clr), .bus(bus));
  itr_priority_ctrl #(.VEC_BASE(8'hFC), .VEC_SHIFT(2)) dut_w (.clk(clk), .clr(clr), .bus(bw));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    bus.itr_ack = 1'b1;
    tick();
    bus.itr_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    bus.itr_ret = 1'b1;
    tick();
    bus.itr_ret = 1'b0;
  endtask

  task automatic test_reset();
    bus.irq = 4'b0001;
    tick(2);
    checks++; if (bus.i_pending !== 1'b1) $display("FAIL rst_pre_pending: got %b want 1", bus.i_pending); else passed++;
    #3 clr = 1'b0;
    #1;
    checks++; if (bus.i_pending !== 1'b0) $display("FAIL rst_async_pending: got %b want 0", bus.i_pending); else passed++;
    checks++; if (bus.pend_out !== 4'b0000) $display("FAIL rst_async_pend: got %b want 0000", bus.pend_out); else passed++;
    bus.irq = 4'b0000;
    tick();
    clr = 1'b1;
    tick(2);
    checks++; if ({bus.i_pending, bus.vec_valid, bus.itr_active, bus.vec_addr} !== 14'd0)
      $display("FAIL rst_idle: got %b/%b/%b/%h want all zero", bus.i_pending, bus.vec_valid, bus.itr_active, bus.vec_addr);
    else passed++;
  endtask

  task automatic test_single();
    bus.irq = 4'b0100;
    tick();
    checks++; if (bus.pend_out !== 4'b0100) $display("FAIL single_pend: got %b want 0100", bus.pend_out); else passed++;
    checks++; if (bus.i_pending !== 1'b0) $display("FAIL single_early_pending: got %b want 0", bus.i_pending); else passed++;
    tick();
    checks++; if (bus.i_pending !== 1'b1) $display("FAIL single_pending: got %b want 1", bus.i_pending); else passed++;
    bus.irq = 4'b0000;
    pulse_ack();
    checks++; if (bus.vec_valid !== 1'b1) $display("FAIL single_vvalid: got %b want 1", bus.vec_valid); else passed++;
    checks++; if (bus.vec_addr !== 8'hF8) $display("FAIL single_vaddr: got %h want f8", bus.vec_addr); else passed++;
    checks++; if (bus.itr_active !== 4'b0100) $display("FAIL single_active: got %b want 0100", bus.itr_active); else passed++;
    checks++; if (bus.pend_out !== 4'b0000) $display("FAIL single_pend_clr: got %b want 0000", bus.pend_out); else passed++;
    tick();
    checks++; if (bus.vec_valid !== 1'b0) $display("FAIL single_vvalid_len: got %b want 0", bus.vec_valid); else passed++;
    pulse_ret();
    checks++; if (bus.itr_active !== 4'b0000) $display("FAIL single_ret: got %b want 0000", bus.itr_active); else passed++;
    checks++; if (bus.vec_addr !== 8'hF8) $display("FAIL single_vaddr_hold: got %h want f8", bus.vec_addr); else passed++;
  endtask

  task automatic test_priority();
    bus.irq = 4'b1010;
    tick();
    bus.irq = 4'b0000;
    tick();
    checks++; if (bus.pend_out !== 4'b1010) $display("FAIL prio_pend: got %b want 1010", bus.pend_out); else passed++;
    pulse_ack();
    checks++; if (bus.vec_addr !== 8'hF4) $display("FAIL prio_first_vec: got %h want f4", bus.vec_addr); else passed++;
    checks++; if (bus.itr_active !== 4'b0010) $display("FAIL prio_first_active: got %b want 0010", bus.itr_active); else passed++;
    tick();
    checks++; if (bus.i_pending !== 1'b0) $display("FAIL prio_wait: got %b want 0", bus.i_pending); else passed++;
    checks++; if (bus.pend_out !== 4'b1000) $display("FAIL prio_pend3: got %b want 1000", bus.pend_out); else passed++;
    pulse_ret();
    tick();
    checks++; if (bus.i_pending !== 1'b1) $display("FAIL prio_second_pending: got %b want 1", bus.i_pending); else passed++;
    pulse_ack();
    checks++; if (bus.vec_addr !== 8'hFC) $display("FAIL prio_second_vec: got %h want fc", bus.vec_addr); else passed++;
    checks++; if (bus.pend_out !== 4'b0000) $display("FAIL prio_pend_done: got %b want 0000", bus.pend_out); else passed++;
    tick();
    pulse_ret();
  endtask

  task automatic test_mask();
    bus.itr_mask = 4'b1110;
    bus.irq = 4'b0001;
    tick();
    bus.irq = 4'b0000;
    tick(2);
    checks++; if (bus.i_pending !== 1'b0) $display("FAIL mask_blocked: got %b want 0", bus.i_pending); else passed++;
    checks++; if (bus.pend_out !== 4'b0001) $display("FAIL mask_pend_kept: got %b want 0001", bus.pend_out); else passed++;
    bus.itr_mask = 4'hF;
    tick();
    checks++; if (bus.i_pending !== 1'b1) $display("FAIL mask_unmask: got %b want 1", bus.i_pending); else passed++;
    bus.itr_mask = 4'h0;
    bus.itr_ack = 1'b1;
    tick();
    bus.itr_ack = 1'b0;
    checks++; if ({bus.i_pending, bus.vec_valid, bus.itr_active} !== 6'd0)
      $display("FAIL mask_drop: got %b/%b/%b want 0/0/0000", bus.i_pending, bus.vec_valid, bus.itr_active);
    else passed++;
    bus.itr_mask = 4'hF;
    tick();
    pulse_ack();
    checks++; if (bus.vec_addr !== 8'hF0) $display("FAIL mask_vec0: got %h want f0", bus.vec_addr); else passed++;
    tick();
    pulse_ret();
  endtask

  task automatic test_nest();
    bus.irq = 4'b0100;
    tick();
    bus.irq = 4'b0000;
    tick();
    pulse_ack();
    tick();
    bus.irq = 4'b0001;
    tick();
    bus.irq = 4'b0000;
    tick();
`ifdef ITR_NEST_EN
    checks++; if (bus.i_pending !== 1'b1) $display("FAIL nest_preempt: got %b want 1", bus.i_pending); else passed++;
    pulse_ack();
    checks++; if (bus.vec_addr !== 8'hF0) $display("FAIL nest_vec: got %h want f0", bus.vec_addr); else passed++;
    checks++; if (bus.itr_active !== 4'b0101) $display("FAIL nest_stack: got %b want 0101", bus.itr_active); else passed++;
    tick();
    pulse_ret();
    checks++; if (bus.itr_active !== 4'b0100) $display("FAIL nest_ret_low: got %b want 0100", bus.itr_active); else passed++;
    pulse_ret();
    checks++; if (bus.itr_active !== 4'b0000) $display("FAIL nest_ret_all: got %b want 0000", bus.itr_active); else passed++;
`else
    tick(2);
    checks++; if (bus.i_pending !== 1'b0) $display("FAIL nonest_hold: got %b want 0", bus.i_pending); else passed++;
    checks++; if (bus.itr_active !== 4'b0100) $display("FAIL nonest_active: got %b want 0100", bus.itr_active); else passed++;
    pulse_ret();
    tick();
    checks++; if (bus.i_pending !== 1'b1) $display("FAIL nonest_after_ret: got %b want 1", bus.i_pending); else passed++;
    pulse_ack();
    checks++; if (bus.itr_active !== 4'b0001) $display("FAIL nonest_active2: got %b want 0001", bus.itr_active); else passed++;
    tick();
    pulse_ret();
`endif
  endtask

  task automatic test_held();
    int n;
    n = 0;
    pulse_ack();
    checks++; if ({bus.vec_valid, bus.itr_active} !== 5'd0)
      $display("FAIL spurious_ack: got %b/%b want 0/0000", bus.vec_valid, bus.itr_active);
    else passed++;
    bus.irq = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      bus.itr_ack = bus.i_pending;
      bus.itr_ret = (bus.itr_active != 4'b0000) && !bus.vec_valid;
      tick();
      if (bus.vec_valid) n++;
    end
    bus.irq = 4'b0000;
    bus.itr_ack = 1'b0;
    bus.itr_ret = 1'b0;
    tick(3);
    checks++; if (n !== 1) $display("FAIL held_accepts: got %0d want 1", n); else passed++;
    checks++; if (bus.itr_active !== 4'b0000) $display("FAIL held_active: got %b want 0000", bus.itr_active); else passed++;
  endtask

  task automatic test_wrap();
    bw.irq = 4'b1000;
    tick();
    bw.irq = 4'b0000;
    tick();
    bw.itr_ack = 1'b1;
    tick();
    bw.itr_ack = 1'b0;
    checks++; if (bw.vec_addr !== 8'h08) $display("FAIL wrap_vec: got %h want 08", bw.vec_addr); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    clr = 1'b0;
    bus.irq = 4'b0000; bus.itr_mask = 4'hF; bus.itr_ack = 1'b0; bus.itr_ret = 1'b0;
    bw.irq = 4'b0000;  bw.itr_mask = 4'hF;  bw.itr_ack = 1'b0;  bw.itr_ret = 1'b0;
    tick(2);
    clr = 1'b1;
    tick();
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_nest();
    test_held();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
